// File: rtl/sram_like_responder.sv
// sram_like_responder: memory-side responder for the req/addr_ok/data_ok sram-like port.
// Latency: data_ok exactly LATENCY edges after acceptance, one pulse per request, in order.
// Backpressure: addr_ok drops while QDEPTH requests are outstanding; no response backpressure.
//
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   req, wr, size        : request valid, 1 = write, access size (informational only)
//   wstrb, addr, wdata   : byte enables (writes only), byte address, write data
//   addr_ok              : request accepted this cycle when req & addr_ok
//   data_ok, rdata       : completion pulse; read data (0 unless a read completes)
//
// Optional feature: define SRAM_RESP_RANDOM_STALL_EN to add LFSR-driven random
// acceptance stalls (about 25% of cycles) for exercising requester hold behaviour.
module sram_like_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int OW = $clog2(QDEPTH + 1);
  localparam logic [OW-1:0] QMAX = OW'(QDEPTH);

  // Backing store; deliberately not reset.
  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0] widx;
  logic                  accept;
  logic                  stall;
  logic [OW-1:0]         outst;

  // Return pipeline: stage 0 is loaded at the accepting edge, stage LATENCY-1 drives data_ok.
  logic [LATENCY-1:0]    p_vld;
  logic [LATENCY-1:0]    p_rd;
  logic [31:0]           p_dat [LATENCY];

  // Upper address bits and byte offset alias; size carries no behaviour.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0]};

  assign widx   = addr[DEPTH_LOG2+1:2];
  assign accept = req & addr_ok;

`ifdef SRAM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free-running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign data_ok = p_vld[LATENCY-1];
  assign rdata   = (p_vld[LATENCY-1] & p_rd[LATENCY-1]) ? p_dat[LATENCY-1] : 32'h0;

  // A completing response frees its slot in the same cycle, so a new request
  // can be taken alongside it even when the queue is full.
  assign addr_ok = resetn & ((outst < QMAX) | data_ok) & ~stall;

  // Write port: byte-granular, committed at the accepting edge.
  always_ff @(posedge clk) begin
    if (accept & wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads sample mem before the same-edge write lands, so a read only sees
  // writes accepted at strictly earlier edges.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_vld <= '0;
      p_rd  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        p_dat[i] <= 32'h0;
      end
    end else begin
      p_vld[0] <= accept;
      p_rd[0]  <= accept & ~wr;
      p_dat[0] <= (accept & ~wr) ? mem[widx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_rd[i]  <= p_rd[i-1];
        p_dat[i] <= p_dat[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outst <= '0;
    end else if (accept & ~data_ok) begin
      outst <= outst + OW'(1);
    end else if (~accept & data_ok) begin
      outst <= outst - OW'(1);
    end
  end

endmodule
